// File: rtl/bcd_xs3_pkg.sv
// Shared types and constants for the BCD <-> Excess-3 converter.
// Used by the digit converter, the interface and the top level.
package bcd_xs3_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      DONE
   } state_t;

   localparam logic MODE_TO_XS3 = 1'b0;
   localparam logic MODE_TO_BCD = 1'b1;

   localparam logic [3:0] XS3_OFFSET = 4'd3;
   localparam logic [3:0] BCD_MAX    = 4'd9;
   localparam logic [3:0] XS3_MIN    = 4'd3;
   localparam logic [3:0] XS3_MAX    = 4'd12;

endpackage

// File: rtl/bcd_xs3_converter_if.sv
// Valid/ready word bus of the converter: producer side in,
// consumer side out. master = environment, slave = converter.
interface bcd_xs3_converter_if #(
   parameter int DIGITS = 4,
   parameter int DW     = 4 * DIGITS,
   parameter int EW     = (DIGITS > 1) ? $clog2(DIGITS) : 1
);
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          in_mode;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_err;
   logic [EW-1:0] out_err_digit;

   modport master (
      output in_valid, in_data, in_mode, out_ready,
      input  in_ready, out_valid, out_data, out_err, out_err_digit
   );

   modport slave (
      input  in_valid, in_data, in_mode, out_ready,
      output in_ready, out_valid, out_data, out_err, out_err_digit
   );
endinterface

// File: rtl/bcd_xs3_digit.sv
// Single-digit BCD <-> XS3 converter, purely combinational.
// BCD_XS3_ERR_EN adds invalid-digit detection and forces 4'hF.
module bcd_xs3_digit
   import bcd_xs3_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       mode,
`ifdef BCD_XS3_ERR_EN
   output logic       invalid,
`endif
   output logic [3:0] result
);

   logic [3:0] sum;

   assign sum = (mode == MODE_TO_BCD) ? digit - XS3_OFFSET
                                      : digit + XS3_OFFSET;

`ifdef BCD_XS3_ERR_EN
   assign invalid = (mode == MODE_TO_BCD)
                  ? ((digit < XS3_MIN) || (digit > XS3_MAX))
                  : (digit > BCD_MAX);
   assign result  = invalid ? 4'hF : sum;
`else
   assign result  = sum;
`endif

endmodule

// File: rtl/bcd_xs3_converter.sv
// Digit-serial BCD <-> Excess-3 word converter, one digit per clock.
// Optional invalid-digit reporting is enabled by BCD_XS3_ERR_EN.
module bcd_xs3_converter
   import bcd_xs3_pkg::*;
#(
   parameter int DIGITS = 4,
   parameter int DW     = 4 * DIGITS
) (
   input logic                 clk,
   input logic                 rst,
   bcd_xs3_converter_if.slave  bus
);

   localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   state_t        state;
   state_t        state_n;
   logic [DW-1:0] in_q;
   logic [DW-1:0] out_q;
   logic          mode_q;
   logic [CW-1:0] cnt;
   logic          rdy_q;
   logic          vld_q;
   logic          err_q;
   logic [CW-1:0] err_dig_q;
   logic [3:0]    dig;
   logic [3:0]    res;
   logic          last;
   logic          accept;

   assign dig    = in_q[4*cnt +: 4];
   assign last   = (cnt == CW'(DIGITS - 1));
   assign accept = (state == IDLE) && rdy_q && bus.in_valid;

`ifdef BCD_XS3_ERR_EN
   logic bad;
`endif

   bcd_xs3_digit u_digit (
      .digit   (dig),
      .mode    (mode_q),
`ifdef BCD_XS3_ERR_EN
      .invalid (bad),
`endif
      .result  (res)
   );

   // Next-state decode: accept, walk the digits, wait for the consumer
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (accept)        state_n = CONV;
         CONV:    if (last)          state_n = DONE;
         DONE:    if (bus.out_ready) state_n = IDLE;
         default:                    state_n = IDLE;
      endcase
   end

   // State register with registered handshake flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         rdy_q <= 1'b0;
         vld_q <= 1'b0;
      end else begin
         state <= state_n;
         rdy_q <= (state_n == IDLE);
         vld_q <= (state_n == DONE);
      end
   end

   // Word capture, per-digit write-back and first-error tracking
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_q      <= '0;
         out_q     <= '0;
         mode_q    <= MODE_TO_XS3;
         cnt       <= '0;
         err_q     <= 1'b0;
         err_dig_q <= '0;
      end else if (accept) begin
         in_q      <= bus.in_data;
         mode_q    <= bus.in_mode;
         out_q     <= '0;
         cnt       <= '0;
         err_q     <= 1'b0;
         err_dig_q <= '0;
      end else if (state == CONV) begin
         out_q[4*cnt +: 4] <= res;
         if (!last) cnt <= cnt + 1'b1;
`ifdef BCD_XS3_ERR_EN
         if (bad && !err_q) begin
            err_q     <= 1'b1;
            err_dig_q <= cnt;
         end
`endif
      end
   end

   assign bus.in_ready  = rdy_q;
   assign bus.out_valid = vld_q;
   assign bus.out_data  = out_q;

`ifdef BCD_XS3_ERR_EN
   assign bus.out_err       = err_q;
   assign bus.out_err_digit = (DIGITS > 1) ? err_dig_q : '0;
`else
   assign bus.out_err       = 1'b0;
   assign bus.out_err_digit = '0;
`endif

endmodule

// File: tb/tb_bcd_xs3_converter.sv
// Self-checking bench for bcd_xs3_converter (DIGITS=4).
// Expectations follow BCD_XS3_ERR_EN when it is defined.
module tb_bcd_xs3_converter;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   bcd_xs3_converter_if #(.DIGITS(4)) bus ();

   bcd_xs3_converter #(.DIGITS(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] data;
      logic        mode;
      logic [15:0] exp_data;
      logic        exp_err;
      logic [1:0]  exp_ed;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   // Reference: each digit shifted by +/-3 modulo 16, invalid -> F
   function automatic void model(input logic [15:0] d, input logic m,
                                 output logic [15:0] o,
                                 output logic e, output logic [1:0] ed);
      o  = '0;
      e  = 1'b0;
      ed = '0;
      for (int i = 0; i < 4; i++) begin
         int v;
         int r;
         v = int'((d >> (4 * i)) & 16'hF);
         r = m ? (v + 13) % 16 : (v + 3) % 16;
`ifdef BCD_XS3_ERR_EN
         if (m ? (v < 3 || v > 12) : (v > 9)) begin
            r = 15;
            if (!e) begin
               e  = 1'b1;
               ed = 2'(i);
            end
         end
`endif
         o = o | (16'(r) << (4 * i));
      end
   endfunction

   // Offer a word, return edges from accept until out_valid is seen
   task automatic send(input logic [15:0] d, input logic m,
                       output int lat);
      int w;
      w = 0;
      @(negedge clk);
      while (!bus.in_ready && w < 40) begin
         @(negedge clk);
         w++;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_mode  = m;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_mode  = ~m;
      bus.in_data  = 16'($urandom);
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   vec_t        vecs[6];
   int          lat;
   int          n;
   logic [15:0] ed_data;
   logic        e_err;
   logic [1:0]  e_ed;
   logic [15:0] held;
   logic [15:0] rd;
   logic        rm;
   logic        seen;

   initial begin
      total = 0;
      bad   = 0;

      vecs[0] = '{16'h1234, 1'b0, 16'h4567, 1'b0, 2'd0};
      vecs[1] = '{16'h9999, 1'b0, 16'hCCCC, 1'b0, 2'd0};
      vecs[2] = '{16'h4567, 1'b1, 16'h1234, 1'b0, 2'd0};
      vecs[3] = '{16'h3333, 1'b1, 16'h0000, 1'b0, 2'd0};
`ifdef BCD_XS3_ERR_EN
      vecs[4] = '{16'h12A4, 1'b0, 16'h45F7, 1'b1, 2'd1};
      vecs[5] = '{16'h0F45, 1'b1, 16'hFF12, 1'b1, 2'd2};
`else
      vecs[4] = '{16'h12A4, 1'b0, 16'h45D7, 1'b0, 2'd0};
      vecs[5] = '{16'h0F45, 1'b1, 16'hDC12, 1'b0, 2'd0};
`endif

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_mode   = 1'b0;
      bus.out_ready = 1'b1;
      rst           = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 0);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_out_data", 32'(bus.out_data), 0);
      chk("rst_out_err", 32'(bus.out_err), 0);
      chk("rst_err_digit", 32'(bus.out_err_digit), 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rel_in_ready", 32'(bus.in_ready), 1);

      for (int i = 0; i < 6; i++) begin
         send(vecs[i].data, vecs[i].mode, lat);
         chk($sformatf("v%0d_lat", i), 32'(lat), 4);
         chk($sformatf("v%0d_data", i), 32'(bus.out_data),
             32'(vecs[i].exp_data));
         chk($sformatf("v%0d_err", i), 32'(bus.out_err),
             32'(vecs[i].exp_err));
         chk($sformatf("v%0d_ed", i), 32'(bus.out_err_digit),
             32'(vecs[i].exp_ed));
         @(posedge clk);
         #1;
      end

      for (int i = 0; i < 40; i++) begin
         rd = 16'($urandom);
         rm = 1'($urandom);
         model(rd, rm, ed_data, e_err, e_ed);
         send(rd, rm, lat);
         chk("rnd_lat", 32'(lat), 4);
         chk("rnd_data", 32'(bus.out_data), 32'(ed_data));
         chk("rnd_err", 32'(bus.out_err), 32'(e_err));
         chk("rnd_ed", 32'(bus.out_err_digit), 32'(e_ed));
         @(posedge clk);
         #1;
      end

      bus.out_ready = 1'b0;
      send(16'h1234, 1'b0, lat);
      chk("bp_lat", 32'(lat), 4);
      held = bus.out_data;
      chk("bp_first", 32'(held), 32'h4567);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h4567;
      bus.in_mode  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("bp_hold_data", 32'(bus.out_data), 32'(held));
         chk("bp_hold_valid", 32'(bus.out_valid), 1);
         chk("bp_hold_ready", 32'(bus.in_ready), 0);
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_hs_ready", 32'(bus.in_ready), 1);
      chk("bp_hs_valid", 32'(bus.out_valid), 0);
      @(posedge clk);
      #1;
      chk("bp_acc_ready", 32'(bus.in_ready), 0);
      bus.in_data = 16'h9999;
      bus.in_mode = 1'b0;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 40) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      chk("bp_period", 32'(n + 1), 6);
      chk("bp_second", 32'(bus.out_data), 32'h1234);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("bp_third_lat", 32'(lat), 4);
      chk("bp_third", 32'(bus.out_data), 32'hCCCC);
      @(posedge clk);
      #1;

      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h5678;
      bus.in_mode  = 1'b0;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("mid_partial", 32'(bus.out_data != 0), 1);
      rst = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(bus.out_valid), 0);
      chk("mid_rst_data", 32'(bus.out_data), 0);
      chk("mid_rst_ready", 32'(bus.in_ready), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rel_ready", 32'(bus.in_ready), 1);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) seen = 1'b1;
      end
      chk("mid_no_done", 32'(seen), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
